lcd_char_controller: RTL and testbench

- Responder side of the lcd_dataIn / lcd_writeStart / lcd_writeDone / lcd_initDone handshake used by the character display clients.
- Powers up and initialises a 16x2 HD44780-compatible character LCD in 8-bit mode, then accepts one ASCII byte per handshake.
- Drives the LCD bus pins with the required setup, enable-pulse and execution timing.
- Tracks the cursor position and inserts DDRAM line-change commands so text wraps line 1 -> line 2 -> line 1.

---
 rtl/lcd_char_controller.sv | 193 +++++++++++++++++++
 tb/tb_lcd_char_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_controller.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_controller
// Brief    : HD44780 16x2 init + byte-write engine with line-wrap commands.
// Revision : 1.0
// ============================================================================
module lcd_char_controller #(
  parameter int POWERUP_CYC = 750000,
  parameter int E_CYC       = 12,
  parameter int CMD_CYC     = 2000,
  parameter int CLEAR_CYC   = 80000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] lcd_dataIn,
  input  logic       lcd_writeStart,
  output logic       lcd_initDone,
  output logic       lcd_writeDone,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {K_INIT, K_DATA, K_WRAP} kind_t;

  localparam logic [19:0] PWR_LAST   = 20'(POWERUP_CYC - 1);
  localparam logic [19:0] E_LAST     = 20'(E_CYC - 1);
  localparam logic [19:0] CMD_LAST   = 20'(CMD_CYC - 1);
  localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_CYC - 1);
  localparam logic [2:0]  LAST_STEP  = 3'd6;

  state_t      state, state_nxt;
  kind_t       kind, kind_nxt;
  logic [19:0] count, count_nxt;
  logic [2:0]  step, step_nxt;
  logic [4:0]  col, col_nxt;
  logic        long_wait, long_wait_nxt;
  logic        rs, rs_nxt;
  logic [7:0]  db, db_nxt;
  logic        init_done, init_done_nxt;

  logic [2:0]  step_sel;
  logic [7:0]  init_cmd;
  logic        init_long;
  logic [4:0]  col_inc;
  logic [19:0] wait_last;

  // Lookup is indexed by the step about to be issued, not the current one.
  assign step_sel  = (state == WAIT) ? step + 3'd1 : 3'd0;
  assign col_inc   = col + 5'd1;
  assign wait_last = long_wait ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    init_cmd  = 8'h38;
    init_long = 1'b1;
    case (step_sel)
      3'd3:    init_long = 1'b0;
      3'd4:    begin init_cmd = 8'h0C; init_long = 1'b0; end
      3'd5:    init_cmd = 8'h01;
      3'd6:    begin init_cmd = 8'h06; init_long = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PWRUP;
      kind      <= K_INIT;
      count     <= '0;
      step      <= '0;
      col       <= '0;
      long_wait <= 1'b0;
      rs        <= 1'b0;
      db        <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      kind      <= kind_nxt;
      count     <= count_nxt;
      step      <= step_nxt;
      col       <= col_nxt;
      long_wait <= long_wait_nxt;
      rs        <= rs_nxt;
      db        <= db_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    kind_nxt      = kind;
    count_nxt     = count + 20'd1;
    step_nxt      = step;
    col_nxt       = col;
    long_wait_nxt = long_wait;
    rs_nxt        = rs;
    db_nxt        = db;
    init_done_nxt = init_done;
    case (state)
      PWRUP: begin
        rs_nxt = 1'b0;
        db_nxt = '0;
        if (count == PWR_LAST) begin
          state_nxt     = SETUP;
          count_nxt     = '0;
          kind_nxt      = K_INIT;
          step_nxt      = '0;
          db_nxt        = init_cmd;
          long_wait_nxt = init_long;
        end
      end
      IDLE: begin
        count_nxt = '0;
        rs_nxt    = 1'b0;
        db_nxt    = '0;
        if (lcd_writeStart) begin
          state_nxt     = SETUP;
          kind_nxt      = K_DATA;
          rs_nxt        = 1'b1;
          db_nxt        = lcd_dataIn;
          long_wait_nxt = 1'b0;
        end
      end
      SETUP: begin
        count_nxt = '0;
        state_nxt = PULSE;
      end
      PULSE: begin
        if (count == E_LAST) begin
          state_nxt = HOLD;
          count_nxt = '0;
        end
      end
      HOLD: begin
        if (count == E_LAST) begin
          state_nxt = WAIT;
          count_nxt = '0;
        end
      end
      WAIT: begin
        if (count == wait_last) begin
          count_nxt = '0;
          state_nxt = DONE;
          case (kind)
            K_INIT: begin
              if (step == LAST_STEP) begin
                state_nxt     = IDLE;
                init_done_nxt = 1'b1;
                rs_nxt        = 1'b0;
                db_nxt        = '0;
              end else begin
                state_nxt     = SETUP;
                step_nxt      = step + 3'd1;
                db_nxt        = init_cmd;
                long_wait_nxt = init_long;
              end
            end
            K_DATA: begin
              col_nxt = col_inc;
              // Entering column 16 or wrapping to 0 needs a DDRAM address set.
              if (col_inc == 5'd16 || col_inc == 5'd0) begin
                state_nxt     = SETUP;
                kind_nxt      = K_WRAP;
                rs_nxt        = 1'b0;
                db_nxt        = (col_inc == 5'd16) ? 8'hC0 : 8'h80;
                long_wait_nxt = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      DONE: begin
        state_nxt = IDLE;
        count_nxt = '0;
        rs_nxt    = 1'b0;
        db_nxt    = '0;
      end
      default: state_nxt = PWRUP;
    endcase
  end

  assign lcd_e         = (state == PULSE);
  assign lcd_writeDone = (state == DONE);
  assign lcd_initDone  = init_done;
  assign lcd_rs        = rs;
  assign lcd_db        = db;
  assign lcd_rw        = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_char_controller
// Brief    : Scoreboard bench for lcd_char_controller (small timing params).
// Revision : 1.0
// ============================================================================
module tb_lcd_char_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] lcd_dataIn = 8'h00;
  logic       lcd_writeStart = 1'b0;
  logic       lcd_initDone, lcd_writeDone, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  int checks = 0;
  int errors = 0;
  int model_col = 0;
  logic [8:0] exp_q[$];
  logic       prev_e = 1'b0;
  int         e_width = 0;

  lcd_char_controller #(
    .POWERUP_CYC(100), .E_CYC(2), .CMD_CYC(10), .CLEAR_CYC(40)
  ) dut (
    .clock(clock), .reset(reset), .lcd_dataIn(lcd_dataIn),
    .lcd_writeStart(lcd_writeStart), .lcd_initDone(lcd_initDone),
    .lcd_writeDone(lcd_writeDone), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  always #5 clock = ~clock;

  // Bus monitor: every enable pulse pops one expected {rs, db} transaction.
  always @(negedge clock) begin
    logic [8:0] want;
    if (!reset) begin
      prev_e  = 1'b0;
      e_width = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: got rs=%0b db=%02h, required no pulse", lcd_rs, lcd_db);
        end else begin
          want = exp_q.pop_front();
          if ({lcd_rs, lcd_db} !== want || lcd_rw !== 1'b0) begin
            errors++;
            $display("FAIL bus_xfer: got rs=%0b db=%02h rw=%0b, required rs=%0b db=%02h rw=0",
                     lcd_rs, lcd_db, lcd_rw, want[8], want[7:0]);
          end
        end
        e_width = 1;
      end else if (lcd_e) begin
        e_width++;
      end else if (prev_e) begin
        checks++;
        if (e_width !== 2) begin
          errors++;
          $display("FAIL e_width: got %0d cycles, required 2", e_width);
        end
      end
      prev_e = lcd_e;
    end
  end

  task automatic push_init();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  // Pushes the expected data write and any wrap command, returns wrap flag.
  task automatic expect_write(input logic [7:0] data, output logic wrap);
    int nc;
    nc = (model_col + 1) % 32;
    exp_q.push_back({1'b1, data});
    wrap = 1'b0;
    if (nc == 16) begin exp_q.push_back({1'b0, 8'hC0}); wrap = 1'b1; end
    if (nc == 0)  begin exp_q.push_back({1'b0, 8'h80}); wrap = 1'b1; end
    model_col = nc;
  endtask

  task automatic write_byte(input logic [7:0] data);
    logic wrap;
    int   lat;
    expect_write(data, wrap);
    @(negedge clock);
    lcd_dataIn = data;
    lcd_writeStart = 1'b1;
    @(posedge clock); #1;
    lcd_writeStart = 1'b0;
    lcd_dataIn = ~data;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (lcd_writeDone) begin lat = i; break; end
    end
    checks++;
    if (lat !== (wrap ? 30 : 15)) begin
      errors++;
      $display("FAIL write_latency: data=%02h got %0d, required %0d", data, lat, wrap ? 30 : 15);
    end
    @(posedge clock); #1;
    checks++;
    if (lcd_writeDone !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got writeDone=%0b second cycle, required 0", lcd_writeDone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    lcd_writeStart = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({lcd_e, lcd_initDone, lcd_writeDone, lcd_rs, lcd_rw, lcd_db} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got e=%0b init=%0b done=%0b rs=%0b rw=%0b db=%02h, required all 0",
               lcd_e, lcd_initDone, lcd_writeDone, lcd_rs, lcd_rw, lcd_db);
    end
  endtask

  task automatic test_init(input logic hold, input logic [7:0] data);
    int   cyc;
    logic saw_done;
    logic wrap;
    push_init();
    model_col = 0;
    lcd_writeStart = hold;
    lcd_dataIn = data;
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    saw_done = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clock); #1;
      if (lcd_writeDone) saw_done = 1'b1;
      if (lcd_initDone) begin cyc = i; break; end
    end
    checks++;
    if (cyc !== 325) begin
      errors++;
      $display("FAIL init_latency: got %0d cycles, required 325", cyc);
    end
    checks++;
    if (exp_q.size() !== 0 || saw_done !== 1'b0) begin
      errors++;
      $display("FAIL init_sequence: got %0d cmds left done_seen=%0b, required 0 and 0",
               exp_q.size(), saw_done);
    end
    if (hold) begin
      expect_write(data, wrap);
      @(posedge clock); #1;
      lcd_writeStart = 1'b0;
      checks++;
      if ({lcd_rs, lcd_db} !== {1'b1, data}) begin
        errors++;
        $display("FAIL held_start: got rs=%0b db=%02h after init, required rs=1 db=%02h",
                 lcd_rs, lcd_db, data);
      end
      cyc = 0;
      for (int i = 1; i <= 100; i++) begin
        @(posedge clock); #1;
        if (lcd_writeDone) begin cyc = i; break; end
      end
      checks++;
      if (cyc !== 15) begin
        errors++;
        $display("FAIL held_latency: got %0d, required 15", cyc);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    exp_q.push_back({1'b1, 8'h55});
    @(negedge clock);
    lcd_dataIn = 8'h55;
    lcd_writeStart = 1'b1;
    @(posedge clock); #1;
    lcd_writeStart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (lcd_e) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_pulse: got no enable pulse, required one");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({lcd_e, lcd_initDone, lcd_writeDone} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: got e=%0b init=%0b done=%0b, required 000",
               lcd_e, lcd_initDone, lcd_writeDone);
    end
    exp_q.delete();
    repeat (3) @(posedge clock);
  endtask

  task automatic test_wrap_line2();
    for (int b = 8'h31; b <= 8'h3F; b++) write_byte(8'(b));
  endtask

  task automatic test_wrap_line1();
    for (int b = 8'h40; b <= 8'h4F; b++) write_byte(8'(b));
    write_byte(8'h5A);
  endtask

  task automatic test_back_to_back();
    logic wrap;
    int   lat;
    expect_write(8'h61, wrap);
    expect_write(8'h61, wrap);
    @(negedge clock);
    lcd_dataIn = 8'h61;
    lcd_writeStart = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (lcd_writeDone) begin lat = i; break; end
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    lcd_writeStart = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (lcd_writeDone) begin lat = lat + 2 + i; break; end
    end
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL back_to_back: got second done at %0d, required 32", lat);
    end
    @(posedge clock); #1;
    checks++;
    if (lcd_writeDone !== 1'b0 || lcd_e !== 1'b0) begin
      errors++;
      $display("FAIL b2b_extra: got done=%0b e=%0b, required 0 0", lcd_writeDone, lcd_e);
    end
  endtask

  initial begin
    test_reset();
    test_init(1'b0, 8'h00);
    write_byte(8'h41);
    test_reset_mid_write();
    test_init(1'b1, 8'h35);
    test_wrap_line2();
    test_wrap_line1();
    test_back_to_back();
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
